// File: rtl/sdhost_cmd_ctrl_if.sv
// Bus bundle for the SD host CMD-path controller: the SD clock level, the
// CMD pin pair, and the CPU register file mirror. The controller takes the
// slave view; whatever drives the register file and the card takes master.
interface sdhost_cmd_ctrl_if;
  logic        sd_clock;
  logic        cmd_pin_in;
  logic        cmd_pin_out;
  logic [31:0] R024h_CPU;
  logic [31:0] R024h_CPU_out;
  logic [15:0] R00eh_CPU;
  logic [15:0] R00eh_CPU_out;
  logic [15:0] R008h_CPU;
  logic [15:0] R008h_CPU_out;
  logic [15:0] R032h_CPU;
  logic [15:0] R032h_CPU_out;

  modport master (
    output sd_clock, cmd_pin_in, R024h_CPU, R00eh_CPU, R008h_CPU, R032h_CPU,
    input  cmd_pin_out, R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out
  );

  modport slave (
    input  sd_clock, cmd_pin_in, R024h_CPU, R00eh_CPU, R008h_CPU, R032h_CPU,
    output cmd_pin_out, R024h_CPU_out, R00eh_CPU_out, R008h_CPU_out, R032h_CPU_out
  );
endinterface

// File: rtl/sdhost_cmd_ctrl.sv
// SD host CMD-line controller. Serializes a 48-bit command frame on every
// rising edge of the (oversampled) SD clock, then optionally collects a
// 48- or 136-bit response and flags timeout / CRC / end-bit / index errors.
module sdhost_cmd_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  sdhost_cmd_ctrl_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE} state_t;

  // One step of the x^7 + x^3 + 1 CRC shift register.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // CRC7 of the 40 leading frame bits (start, direction, index, argument).
  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  state_t         r_state, w_state_next;
  logic           r_sd_clock_q;
  logic           r_start_q;
  logic           r_pin, w_pin_next;
  logic           r_inhibit, w_inhibit_next;
  logic           r_complete, w_complete_next;
  logic [3:0]     r_err, w_err_next;
  logic [3:0]     w_err_set;
  logic           w_err_clr;
  logic [15:0]    r_cmd, w_cmd_next;
  logic [15:0]    r_arg, w_arg_next;
  logic [47:0]    r_frame, w_frame_next;
  logic [7:0]     r_bit_cnt, w_bit_cnt_next;
  logic [TW-1:0]  r_to_cnt, w_to_cnt_next;
  logic [6:0]     r_crc, w_crc_next;
  logic [135:0]   r_rx, w_rx_next;
  logic [127:0]   r_resp, w_resp_next;

  logic           w_sd_tick;
  logic           w_start_edge;
  logic           w_long;
  logic [7:0]     w_rx_total;
  logic [135:0]   w_rx_shift;
  logic [39:0]    w_frame_head;
  logic           w_unused_bits;

  assign w_sd_tick    = bus.sd_clock & ~r_sd_clock_q;
  assign w_start_edge = bus.R024h_CPU[31] & ~r_start_q;
  assign w_long       = (r_cmd[1:0] == 2'b01);
  assign w_rx_total   = w_long ? 8'd136 : 8'd48;
  assign w_rx_shift   = {r_rx[134:0], bus.cmd_pin_in};
  assign w_frame_head = {2'b01, bus.R00eh_CPU[13:8], 16'h0000, bus.R008h_CPU};

  // The response register has no port of its own; keep it and the
  // don't-care register bits visibly consumed.
  assign w_unused_bits = ^{bus.R024h_CPU[1:0], bus.R032h_CPU[15:4], r_resp};

  assign bus.cmd_pin_out   = r_pin;
  assign bus.R024h_CPU_out = {bus.R024h_CPU[31:2], r_complete, r_inhibit};
  assign bus.R00eh_CPU_out = r_cmd;
  assign bus.R008h_CPU_out = r_arg;
  assign bus.R032h_CPU_out = {12'h000, r_err};

  // State and datapath registers; reset returns the CMD line to idle-high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sd_clock_q <= 1'b0;
      r_start_q    <= 1'b0;
      r_pin        <= 1'b1;
      r_inhibit    <= 1'b0;
      r_complete   <= 1'b0;
      r_err        <= '0;
      r_cmd        <= '0;
      r_arg        <= '0;
      r_frame      <= '0;
      r_bit_cnt    <= '0;
      r_to_cnt     <= '0;
      r_crc        <= '0;
      r_rx         <= '0;
      r_resp       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_sd_clock_q <= bus.sd_clock;
      r_start_q    <= bus.R024h_CPU[31];
      r_pin        <= w_pin_next;
      r_inhibit    <= w_inhibit_next;
      r_complete   <= w_complete_next;
      r_err        <= w_err_next;
      r_cmd        <= w_cmd_next;
      r_arg        <= w_arg_next;
      r_frame      <= w_frame_next;
      r_bit_cnt    <= w_bit_cnt_next;
      r_to_cnt     <= w_to_cnt_next;
      r_crc        <= w_crc_next;
      r_rx         <= w_rx_next;
      r_resp       <= w_resp_next;
    end
  end

  // Next-state and datapath decisions; everything advances only on sd_tick,
  // so a stopped SD clock freezes the command wherever it is.
  always_comb begin
    w_state_next    = r_state;
    w_pin_next      = r_pin;
    w_inhibit_next  = r_inhibit;
    w_complete_next = r_complete;
    w_cmd_next      = r_cmd;
    w_arg_next      = r_arg;
    w_frame_next    = r_frame;
    w_bit_cnt_next  = r_bit_cnt;
    w_to_cnt_next   = r_to_cnt;
    w_crc_next      = r_crc;
    w_rx_next       = r_rx;
    w_resp_next     = r_resp;
    w_err_set       = '0;
    w_err_clr       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_cmd_next      = bus.R00eh_CPU;
          w_arg_next      = bus.R008h_CPU;
          w_frame_next    = {w_frame_head, crc7_40(w_frame_head), 1'b1};
          w_bit_cnt_next  = '0;
          w_inhibit_next  = 1'b1;
          w_complete_next = 1'b0;
          w_err_clr       = 1'b1;
          w_state_next    = S_SEND;
        end
      end

      S_SEND: begin
        if (w_sd_tick) begin
          if (r_bit_cnt == 8'd48) begin
            // Whole frame is out: release the line, then listen if needed.
            w_pin_next = 1'b1;
            if (r_cmd[1:0] == 2'b00) begin
              w_state_next = S_DONE;
            end else begin
              w_to_cnt_next = '0;
              w_state_next  = S_WAIT;
            end
          end else begin
            w_pin_next     = r_frame[47];
            w_frame_next   = {r_frame[46:0], 1'b1};
            w_bit_cnt_next = r_bit_cnt + 8'd1;
          end
        end
      end

      S_WAIT: begin
        if (w_sd_tick) begin
          if (!bus.cmd_pin_in) begin
            // The start bit is the first response bit; it is a zero, so the
            // cleared shift register and CRC already account for it.
            w_rx_next      = '0;
            w_crc_next     = '0;
            w_bit_cnt_next = 8'd1;
            w_state_next   = S_RECV;
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            w_err_set[0] = 1'b1;
            w_state_next = S_DONE;
          end else begin
            w_to_cnt_next = r_to_cnt + 1'b1;
          end
        end
      end

      S_RECV: begin
        if (w_sd_tick) begin
          w_rx_next      = w_rx_shift;
          w_bit_cnt_next = r_bit_cnt + 8'd1;
          // r_bit_cnt is the position of the arriving bit counted from the
          // start bit; only the CRC-covered span feeds the checker.
          if (w_long) begin
            if (r_bit_cnt >= 8'd8 && r_bit_cnt < 8'd128)
              w_crc_next = crc7_step(r_crc, bus.cmd_pin_in);
          end else begin
            if (r_bit_cnt < 8'd40)
              w_crc_next = crc7_step(r_crc, bus.cmd_pin_in);
          end
          if (r_bit_cnt == w_rx_total - 8'd1) begin
            w_resp_next = w_rx_shift[127:0];
            if (!w_rx_shift[0]) w_err_set[2] = 1'b1;
            if (r_crc != w_rx_shift[7:1]) w_err_set[1] = 1'b1;
            if (w_long) begin
              if (w_rx_shift[134]) w_err_set[2] = 1'b1;
            end else begin
              if (w_rx_shift[46]) w_err_set[2] = 1'b1;
              if (w_rx_shift[45:40] != r_cmd[13:8]) w_err_set[3] = 1'b1;
            end
            w_state_next = S_DONE;
          end
        end
      end

      S_DONE: begin
        w_inhibit_next  = 1'b0;
        w_complete_next = 1'b1;
        w_state_next    = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Sticky errors: write-1-to-clear, a fresh start wipes them, and a new
    // error raised in the same clock as a clear wins.
    if (w_err_clr)
      w_err_next = '0;
    else
      w_err_next = (r_err & ~bus.R032h_CPU[3:0]) | w_err_set;
  end

endmodule

// File: tb/tb_sdhost_cmd_ctrl.sv
// Self-checking bench for sdhost_cmd_ctrl: directed CMD0/CMD8/timeout/reset
// cases followed by randomized commands and responses, scored against a
// polynomial-division reference model.
module tb_sdhost_cmd_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_checks = 0;

  always #5 clk = ~clk;

  sdhost_cmd_ctrl_if u_if ();

  sdhost_cmd_ctrl #(.TIMEOUT(64)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (u_if.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] ref_crc(input logic [135:0] msg, input int nbits);
    logic [143:0] r;
    r = {8'h00, msg} << 7;
    for (int i = nbits + 6; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [15:0] arg);
    logic [39:0] m;
    m = {2'b01, idx, 16'h0000, arg};
    return {m, ref_crc(136'(m), 40), 1'b1};
  endfunction

  function automatic logic [135:0] good_rsp48(input logic [5:0] idx, input logic [31:0] body);
    logic [39:0] m;
    m = {2'b00, idx, body};
    return {88'h0, m, ref_crc(136'(m), 40), 1'b1};
  endfunction

  function automatic logic [135:0] good_rsp136(input logic [119:0] payload);
    return {2'b00, 6'h3f, payload, ref_crc(136'(payload), 120), 1'b1};
  endfunction

  // Expected error bits for a command given how the card behaved.
  function automatic logic [3:0] ref_err(input logic [15:0] cmd, input int delay,
                                         input logic [135:0] rsp);
    logic [3:0] e;
    e = 4'h0;
    if (cmd[1:0] == 2'b00) return e;
    if (delay >= 64) return 4'h1;
    if (!rsp[0]) e[2] = 1'b1;
    if (cmd[1:0] == 2'b01) begin
      if (rsp[134]) e[2] = 1'b1;
      if (ref_crc(136'(rsp[127:8]), 120) != rsp[7:1]) e[1] = 1'b1;
    end else begin
      if (rsp[46]) e[2] = 1'b1;
      if (ref_crc(136'(rsp[47:8]), 40) != rsp[7:1]) e[1] = 1'b1;
      if (rsp[45:40] != cmd[13:8]) e[3] = 1'b1;
    end
    return e;
  endfunction

  // One SD clock period of random length; returns the CMD pin just after
  // the rising edge has been seen.
  task automatic sd_pulse(input logic din, output logic dout);
    @(negedge clk);
    u_if.cmd_pin_in = din;
    u_if.sd_clock   = 1'b1;
    @(negedge clk);
    dout = u_if.cmd_pin_out;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    u_if.sd_clock = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic start_cmd(input logic [15:0] cmd, input logic [15:0] arg);
    @(negedge clk);
    u_if.R00eh_CPU     = cmd;
    u_if.R008h_CPU     = arg;
    u_if.R024h_CPU[31] = 1'b1;
    @(negedge clk);
    u_if.R024h_CPU[31] = 1'b0;
    u_if.R00eh_CPU     = 16'($urandom);
    u_if.R008h_CPU     = 16'($urandom);
    check_val("busy_at_start", 64'(u_if.R024h_CPU_out[1:0]), 64'(2'b01));
    check_val("err_cleared", 64'(u_if.R032h_CPU_out), 64'h0);
  endtask

  task automatic run_cmd(input logic [15:0] cmd, input logic [15:0] arg, input int delay,
                         input logic [135:0] rsp, input bit glitch);
    logic [47:0] got;
    logic [47:0] exp_frame;
    logic [3:0]  exp_err;
    logic        b;
    int          total;
    int          nwait;
    exp_frame = ref_frame(cmd[13:8], arg);
    exp_err   = ref_err(cmd, delay, rsp);
    got       = '0;
    start_cmd(cmd, arg);
    for (int k = 0; k < 48; k++) begin
      if (glitch && k == 10) begin
        @(negedge clk);
        u_if.R00eh_CPU     = ~cmd;
        u_if.R008h_CPU     = ~arg;
        u_if.R024h_CPU[31] = 1'b1;
        @(negedge clk);
        u_if.R024h_CPU[31] = 1'b0;
      end
      sd_pulse(1'b1, b);
      got[47-k] = b;
      if (glitch && k == 20) begin
        repeat (40) @(negedge clk);
        check_val("hold_pin", 64'(u_if.cmd_pin_out), 64'(exp_frame[27]));
        check_val("hold_busy", 64'(u_if.R024h_CPU_out[1:0]), 64'(2'b01));
      end
    end
    check_val("frame", 64'(got), 64'(exp_frame));
    sd_pulse(1'b1, b);
    check_val("pin_release", 64'(b), 64'h1);
    if (cmd[1:0] != 2'b00) begin
      total = (cmd[1:0] == 2'b01) ? 136 : 48;
      nwait = (delay >= 64) ? 64 : delay;
      for (int w = 0; w < nwait; w++) begin
        if (w == 63) check_val("busy_before_timeout", 64'(u_if.R024h_CPU_out[0]), 64'h1);
        sd_pulse(1'b1, b);
      end
      if (delay < 64)
        for (int i = total - 1; i >= 0; i--) sd_pulse(rsp[i], b);
    end
    repeat (3) @(negedge clk);
    check_val("status_done", 64'(u_if.R024h_CPU_out[1:0]), 64'(2'b10));
    check_val("err", 64'(u_if.R032h_CPU_out), 64'(exp_err));
    check_val("latched_cmd", 64'(u_if.R00eh_CPU_out), 64'(cmd));
    check_val("latched_arg", 64'(u_if.R008h_CPU_out), 64'(arg));
    $display("cmd idx=%0d type=%0d arg=0x%04h delay=%0d err=0x%0h exp_err=0x%0h",
             cmd[13:8], cmd[1:0], arg, delay, u_if.R032h_CPU_out, exp_err);
  endtask

  task automatic w1c(input logic [15:0] mask, input logic [15:0] exp);
    @(negedge clk);
    u_if.R032h_CPU = mask;
    @(negedge clk);
    u_if.R032h_CPU = 16'h0000;
    check_val("w1c", 64'(u_if.R032h_CPU_out), 64'(exp));
  endtask

  initial begin
    logic         b;
    logic [15:0]  cmd;
    logic [15:0]  arg;
    logic [135:0] rsp;
    logic [127:0] wide;
    logic [5:0]   ridx;
    int           delay;
    int           sc;
    int           total;
    int           pos;

    rst                = 1'b1;
    u_if.sd_clock      = 1'b0;
    u_if.cmd_pin_in    = 1'b1;
    u_if.R024h_CPU     = 32'h0ABC_DEF3;
    u_if.R00eh_CPU     = 16'h0000;
    u_if.R008h_CPU     = 16'h0000;
    u_if.R032h_CPU     = 16'h0000;

    // Reset with the SD clock running.
    repeat (6) begin
      @(negedge clk) u_if.sd_clock = ~u_if.sd_clock;
    end
    check_val("rst_pin", 64'(u_if.cmd_pin_out), 64'h1);
    check_val("rst_status", 64'(u_if.R024h_CPU_out[1:0]), 64'h0);
    check_val("rst_mirror", 64'(u_if.R024h_CPU_out[31:2]), 64'(30'h02AF37BC));
    check_val("rst_err", 64'(u_if.R032h_CPU_out), 64'h0);
    check_val("rst_cmd", 64'(u_if.R00eh_CPU_out), 64'h0);
    @(negedge clk);
    u_if.sd_clock = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // CMD0, no response; frame is 0x400000000095.
    check_val("cmd0_model", 64'(ref_frame(6'd0, 16'h0000)), 64'h4000_0000_0095);
    run_cmd(16'h0000, 16'h0000, 0, '0, 1'b0);
    // CMD8 with a well-formed R7, a bad CRC, and a wrong index.
    run_cmd(16'h0802, 16'h01AA, 2, 136'h08000001AA13, 1'b0);
    run_cmd(16'h0802, 16'h01AA, 0, 136'h08000001AA11, 1'b0);
    run_cmd(16'h0802, 16'h01AA, 1, 136'h09000001AA13, 1'b0);
    w1c(16'h0002, 16'(ref_err(16'h0802, 1, 136'h09000001AA13) & 4'b1101));
    // Silent card: timeout on the 64th tick, then clear it; 63 idle ticks is fine.
    run_cmd(16'h1102, 16'h5A5A, 64, '0, 1'b0);
    w1c(16'h0001, 16'h0000);
    run_cmd(16'h1102, 16'h5A5A, 63, good_rsp48(6'd17, 32'h0000_0900), 1'b0);
    // Start edge during SEND is ignored, and a stopped SD clock holds state.
    run_cmd(16'h0d03, 16'hBEEF, 3, good_rsp48(6'd13, 32'h1234_5678), 1'b1);

    // Reset in the middle of a 136-bit response.
    start_cmd(16'h0201, 16'h0000);
    for (int k = 0; k < 49; k++) sd_pulse(1'b1, b);
    sd_pulse(1'b0, b);
    repeat (5) sd_pulse(1'($urandom), b);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_pin", 64'(u_if.cmd_pin_out), 64'h1);
    check_val("midrst_status", 64'(u_if.R024h_CPU_out[1:0]), 64'h0);
    check_val("midrst_cmd", 64'(u_if.R00eh_CPU_out), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    u_if.cmd_pin_in = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized commands and card behaviour.
    for (int t = 0; t < 16; t++) begin
      cmd      = 16'($urandom);
      arg      = 16'($urandom);
      sc       = $urandom_range(0, 9);
      delay    = (sc == 0) ? 64 : $urandom_range(0, 8);
      if (cmd[1:0] == 2'b01) begin
        wide  = {$urandom, $urandom, $urandom, $urandom};
        rsp   = good_rsp136(wide[119:0]);
        total = 136;
      end else begin
        ridx  = (sc == 5) ? (cmd[13:8] ^ 6'(1 + $urandom_range(0, 62))) : cmd[13:8];
        rsp   = good_rsp48(ridx, $urandom);
        total = 48;
      end
      if (sc >= 6) begin
        pos      = $urandom_range(0, total - 2);
        rsp[pos] = ~rsp[pos];
      end
      run_cmd(cmd, arg, delay, rsp, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sdhost_cmd_ctrl.md
Name: sdhost_cmd_ctrl

Overview:
SD host command-line controller, CMD path only. It sits between the CPU register file and the SD card CMD pin. It serializes a 48-bit command frame (index, argument, CRC7) onto cmd_pin_out, paced by sd_clock. It then optionally receives and checks a 48-bit or 136-bit response on cmd_pin_in and reports status and errors back through the register mirror outputs.

Parameters:
TIMEOUT  64  sd_clock rising edges to wait for a response start bit before flagging a timeout.

Ports:
clock  in  1  system clock; all logic is clocked on its rising edge.
reset  in  1  asynchronous, active-high reset.
sd_clock  in  1  SD bus clock level; treated as data and sampled by clock. Each detected 0->1 transition is one bit tick (sd_tick).
cmd_pin_in  in  1  CMD line from the card (response).
cmd_pin_out  out  1  CMD line to the card; idles at 1.
R024h_CPU  in  32  present-state/control register. Bit31 = start request; a rising edge starts a command.
R024h_CPU_out  out  32  {R024h_CPU[31:2], cmd_complete, cmd_inhibit}.
R00eh_CPU  in  16  command register. [13:8] = command index; [1:0] = response type (00 none, 01 136-bit, 10 48-bit, 11 48-bit).
R00eh_CPU_out  out  16  command register value latched at start.
R008h_CPU  in  16  argument. The 32-bit frame argument is {16'h0000, R008h_CPU}.
R008h_CPU_out  out  16  argument latched at start.
R032h_CPU  in  16  error-status write-1-to-clear mask, applied every clock.
R032h_CPU_out  out  16  error status: [0] timeout, [1] CRC, [2] end bit, [3] index, [15:4] = 0.

Behaviour:
- Reset values: cmd_pin_out=1; cmd_inhibit=0; cmd_complete=0; errors=0; latched command and argument = 0; state IDLE.
- sd_tick = sd_clock & ~sd_clock_q, where sd_clock_q is sd_clock registered on clock. Start-request edge is detected the same way on R024h_CPU[31].
- IDLE, on start edge:
  - Latch R00eh_CPU and R008h_CPU.
  - Build frame = {0, 1, idx[5:0], arg[31:0], crc7, 1}. crc7 uses polynomial x^7+x^3+1, init 0, computed over the first 40 bits.
  - Set cmd_inhibit=1, clear cmd_complete and all error bits, go to SEND.
  - A start edge outside IDLE is ignored.
- SEND: on each sd_tick, drive the next frame bit (MSB first) on cmd_pin_out. On the sd_tick after bit 0, drive cmd_pin_out=1, then:
  - type 00 -> DONE;
  - otherwise -> WAIT, with the timeout counter cleared.
- WAIT: on each sd_tick, sample cmd_pin_in.
  - 0 -> RECV; that start bit counts as the first received bit.
  - Else increment the counter; when it reaches TIMEOUT, set timeout error -> DONE.
- RECV: shift cmd_pin_in in on each sd_tick until 48 (types 10/11) or 136 (type 01) bits total, then check:
  - Bit 46 (48-bit) or bit 134 (136-bit) must be 0, else end-bit error.
  - Last bit must be 1, else end-bit error.
  - CRC error if crc7 does not match. For 48-bit, CRC is over bits [47:8]. For 136-bit, CRC is over bits [127:8] of the payload, compared to bits [7:1].
  - Index error (48-bit only) if bits [45:40] ≠ latched index.
  - Then -> DONE. The response is held in an internal 128-bit register, bits [127:0] excluding the start/transmission header.
- DONE: after one clock, cmd_inhibit=0, cmd_complete=1 (sticky until next start) -> IDLE.
- Error bits are sticky. They clear on the next start, or per bit when the matching R032h_CPU bit is 1 in a clock. An error set and a clear in the same cycle -> set wins.
- Reset asserted mid-command: everything returns to reset values immediately; cmd_pin_out=1.
- sd_clock stopped: the FSM holds its state indefinitely.

Test Plan:
- Reset with sd_clock toggling -> cmd_pin_out=1, R024h_CPU_out[1:0]=00, R032h_CPU_out=0.
- CMD0: R00eh=0x0000, R008h=0, start -> cmd_pin_out shows 0x400000000095 MSB first over 48 sd_ticks. cmd_complete=1, no errors, R00eh_CPU_out=0x0000.
- CMD8: R00eh=0x0802, R008h=0x01AA -> transmits 0x48000001AA87. Card drives 0x08000001AA13 -> cmd_complete=1, R032h_CPU_out=0x0000.
- Same CMD8 with response last byte 0x11 -> R032h_CPU_out=0x0002 (CRC). With index 0x09 -> index bit set.
- Type 10 command, cmd_pin_in held 1 -> after 64 sd_ticks R032h_CPU_out=0x0001, cmd_inhibit drops. Writing R032h_CPU=0x0001 clears it.
- Start edge during SEND ignored; reset pulse during RECV -> idle outputs within one clock.
